hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline hazard controller. Detects load-use and data hazards
//             on decode-stage sources, stalls around multicycle EX ops,
//             squashes IF-ID/ID-EX on an EX redirect, selects EX operand
//             forwarding and counts stall cycles.
//  Config   : HAZARD_FWD_EN defined   -> EX forwarding from MEM/WB, only
//                                        load-use hazards stall.
//             HAZARD_FWD_EN undefined -> no forwarding (fwd_a/fwd_b = 0),
//                                        any EX or MEM producer match stalls.
//  Ports    : clk, rst (async, active-low)
//             id_*   : decode source registers and valid flags
//             ex_*   : ID/EX destination, load flag, EX sources, redirect,
//                      multicycle start
//             mem_*, wb_* : EX/MEM and MEM/WB destinations
//             pc_stall, ifid_stall, ifid_flush, pipelineFlush,
//             idex_hazarded, ex_stall : pipeline control
//             fwd_a, fwd_b : EX operand select (00 reg, 01 MEM, 10 WB)
//             hz_state : FSM state, stall_cnt : saturating stall counter
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int MC_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_reg_waddr,
   input  logic        ex_reg_wena,
   input  logic        ex_mem_rena,
   input  logic [4:0]  ex_rs1_addr,
   input  logic [4:0]  ex_rs2_addr,
   input  logic [4:0]  mem_reg_waddr,
   input  logic        mem_reg_wena,
   input  logic [4:0]  wb_reg_waddr,
   input  logic        wb_reg_wena,
   input  logic        ex_redirect,
   input  logic        ex_mc_start,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        pipelineFlush,
   output logic        idex_hazarded,
   output logic        ex_stall,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [1:0]  hz_state,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] c_ST_RUN    = 2'b00;
   localparam logic [1:0] c_ST_STALL  = 2'b01;
   localparam logic [1:0] c_ST_MCWAIT = 2'b10;

   // The start cycle in RUN is the first of MC_LAT stall cycles, so MCWAIT
   // runs MC_LAT-1 cycles: counter values MC_LAT-2 down to 0.
   localparam logic [3:0] c_MC_LOAD = 4'(MC_LAT - 2);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [3:0]  r_wait_cnt;
   logic [3:0]  w_wait_nxt;
   logic [15:0] r_stall_cnt;

   logic        w_rs1_ex_hit;
   logic        w_rs2_ex_hit;
   logic        w_load_use;
   logic        w_hazard;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   assign w_rs1_ex_hit = id_rs1_used & (id_rs1_addr == ex_reg_waddr);
   assign w_rs2_ex_hit = id_rs2_used & (id_rs2_addr == ex_reg_waddr);
   assign w_load_use   = ex_mem_rena & ex_reg_wena & (ex_reg_waddr != 5'd0)
                       & (w_rs1_ex_hit | w_rs2_ex_hit);

`ifdef HAZARD_FWD_EN
   // Only a load in EX cannot be covered by forwarding.
   assign w_hazard = w_load_use;

   // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
   function automatic logic [1:0] f_fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] mem_waddr,
      input logic       mem_wena,
      input logic [4:0] wb_waddr,
      input logic       wb_wena
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_wena && (mem_waddr != 5'd0) && (mem_waddr == rs)) begin
         sel = 2'b01;
      end else if (wb_wena && (wb_waddr != 5'd0) && (wb_waddr == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   assign fwd_a = f_fwd_sel(ex_rs1_addr, mem_reg_waddr, mem_reg_wena,
                            wb_reg_waddr, wb_reg_wena);
   assign fwd_b = f_fwd_sel(ex_rs2_addr, mem_reg_waddr, mem_reg_wena,
                            wb_reg_waddr, wb_reg_wena);
`else
   logic w_ex_hit;
   logic w_mem_hit;
   logic w_unused_fwd;

   // Without forwarding any pending producer in EX or MEM must drain first;
   // WB is assumed to write through the register file in the same cycle.
   assign w_ex_hit  = ex_reg_wena & (ex_reg_waddr != 5'd0)
                    & (w_rs1_ex_hit | w_rs2_ex_hit);
   assign w_mem_hit = mem_reg_wena & (mem_reg_waddr != 5'd0)
                    & ((id_rs1_used & (id_rs1_addr == mem_reg_waddr))
                     | (id_rs2_used & (id_rs2_addr == mem_reg_waddr)));
   assign w_hazard  = w_load_use | w_ex_hit | w_mem_hit;

   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;

   assign w_unused_fwd = ^{ex_rs1_addr, ex_rs2_addr, wb_reg_waddr, wb_reg_wena};
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= c_ST_RUN;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      case (r_state)
         c_ST_RUN: begin
            if (ex_redirect) begin
               w_state_nxt = c_ST_RUN;
            end else if (ex_mc_start) begin
               w_state_nxt = c_ST_MCWAIT;
               w_wait_nxt  = c_MC_LOAD;
            end else if (w_hazard) begin
               w_state_nxt = c_ST_STALL;
            end
         end
         c_ST_STALL: begin
            if (ex_redirect) begin
               w_state_nxt = c_ST_RUN;
            end else if (w_hazard) begin
               w_state_nxt = c_ST_STALL;
            end else begin
               w_state_nxt = c_ST_RUN;
            end
         end
         c_ST_MCWAIT: begin
            if (r_wait_cnt == 4'd0) begin
               w_state_nxt = c_ST_RUN;
            end else begin
               w_wait_nxt = r_wait_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = c_ST_RUN;
            w_wait_nxt  = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      pc_stall      = 1'b0;
      ifid_stall    = 1'b0;
      ifid_flush    = 1'b0;
      pipelineFlush = 1'b0;
      idex_hazarded = 1'b0;
      ex_stall      = 1'b0;
      case (r_state)
         c_ST_RUN: begin
            if (ex_redirect) begin
               pipelineFlush = 1'b1;
               ifid_flush    = 1'b1;
            end else if (ex_mc_start) begin
               ex_stall   = 1'b1;
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
            end else if (w_hazard) begin
               pc_stall      = 1'b1;
               ifid_stall    = 1'b1;
               idex_hazarded = 1'b1;
            end
         end
         c_ST_STALL: begin
            if (ex_redirect) begin
               pipelineFlush = 1'b1;
               ifid_flush    = 1'b1;
            end else if (w_hazard) begin
               pc_stall      = 1'b1;
               ifid_stall    = 1'b1;
               idex_hazarded = 1'b1;
            end
         end
         c_ST_MCWAIT: begin
            // The multicycle op stays in EX; no bubble is inserted.
            ex_stall   = 1'b1;
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Saturating stall-cycle counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= 16'd0;
      end else if (pc_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign hz_state  = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
